// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and data width.
// The transmitter uses the same encodings so the two stay in step.
package uart_rx_pkg;

   localparam int data_width = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Single-bit two-flop synchronizer with a parameterised reset value, used to bring
// the asynchronous rx pad into the clock domain.
module uart_rx_sync_2ff #(
   parameter logic reset_value = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [1:0] stage_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stage_reg <= {2{reset_value}};
      end else begin
         stage_reg <= {stage_reg[0], d};
      end
   end

   assign q = stage_reg[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its midpoint (clock_bit+1 clocks per bit)
// and reports a good byte with done, or a low stop bit with ferr.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter logic [15:0] clock_bit = 16'd434
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rx,
   output logic [data_width-1:0] readdata,
   output logic                  done,
   output logic                  ferr,
   output logic                  busy
);

   localparam logic [15:0] half_bit = clock_bit >> 1;

   logic                  rx_s;
   state_t                state_reg;
   logic [15:0]           counter_reg;
   logic [2:0]            index_reg;
   logic [data_width-1:0] shift_reg;
   logic [data_width-1:0] readdata_reg;
   logic                  done_reg;
   logic                  ferr_reg;

   uart_rx_sync_2ff #(
      .reset_value(1'b1)
   ) u_sync (
      .clock(clock),
      .reset(reset),
      .d    (rx),
      .q    (rx_s)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         counter_reg  <= 16'd0;
         index_reg    <= 3'd0;
         shift_reg    <= '0;
         readdata_reg <= '0;
         done_reg     <= 1'b0;
         ferr_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         ferr_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               counter_reg <= 16'd0;
               index_reg   <= 3'd0;
               if (!rx_s) state_reg <= START;
            end
            START: begin
               // A start bit that is no longer low at its midpoint is treated as noise.
               if (counter_reg == half_bit) begin
                  counter_reg <= 16'd0;
                  state_reg   <= rx_s ? IDLE : DATA;
               end else begin
                  counter_reg <= counter_reg + 16'd1;
               end
            end
            DATA: begin
               if (counter_reg == clock_bit) begin
                  counter_reg          <= 16'd0;
                  shift_reg[index_reg] <= rx_s;
                  if (index_reg == 3'd7) begin
                     state_reg <= STOP;
                  end else begin
                     index_reg <= index_reg + 3'd1;
                  end
               end else begin
                  counter_reg <= counter_reg + 16'd1;
               end
            end
            STOP: begin
               if (counter_reg == clock_bit) begin
                  counter_reg <= 16'd0;
                  if (rx_s) begin
                     readdata_reg <= shift_reg;
                     done_reg     <= 1'b1;
                     state_reg    <= IDLE;
                  end else begin
                     ferr_reg  <= 1'b1;
                     state_reg <= BREAK;
                  end
               end else begin
                  counter_reg <= counter_reg + 16'd1;
               end
            end
            BREAK: begin
               // Hold off start detection until the line has gone idle again.
               counter_reg <= 16'd0;
               if (rx_s) state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign readdata = readdata_reg;
   assign done     = done_reg;
   assign ferr     = ferr_reg;
   assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven asynchronously in real time and
// the received bytes / error pulses are compared against a frame-level expectation.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam logic [15:0] clock_bit = 16'd15;
   localparam int          bit_ns    = 160;    // 16 clocks of 10 ns

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic [7:0] readdata;
   logic       done;
   logic       ferr;
   logic       busy;

   uart_rx #(
      .clock_bit(clock_bit)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .rx      (rx),
      .readdata(readdata),
      .done    (done),
      .ferr    (ferr),
      .busy    (busy)
   );

   always #5 clock = ~clock;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         ferr_seen = 0;
   int         ferr_exp  = 0;
   int         both_seen = 0;
   int         wide_seen = 0;
   logic [7:0] last_good = 8'h00;
   logic       prev_done = 1'b0;
   logic       prev_ferr = 1'b0;

   // Observe outputs 1 ns after each rising edge.
   always @(posedge clock) begin
      #1;
      if (done) got_q.push_back(readdata);
      if (ferr) ferr_seen++;
      if (done && ferr) both_seen++;
      if ((done && prev_done) || (ferr && prev_ferr)) wide_seen++;
      prev_done = done;
      prev_ferr = ferr;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Drives one frame starting 3 ns after a rising edge; the line is left at the stop level.
   // A high stop bit means the byte must be delivered, a low one means one framing error.
   task automatic send_frame(input logic [7:0] b, input int period_ns, input logic stop_val);
      logic [9:0] f;
      f = {stop_val, b, 1'b0};
      @(posedge clock);
      #3;
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         #(period_ns);
      end
      if (stop_val) begin
         exp_q.push_back(b);
         last_good = b;
      end else begin
         ferr_exp++;
      end
   endtask

   task automatic settle_and_compare(input string tag);
      repeat (40) @(posedge clock);
      #1;
      check_val({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check_val({tag, "_data"}, got_q[i], exp_q[i]);
      check_val({tag, "_ferr"}, ferr_seen, ferr_exp);
      check_val({tag, "_readdata"}, readdata, last_good);
      check_val({tag, "_idle"}, busy, 0);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [7:0] v55;
      logic [7:0] b;
      int         p;
      logic       stop_v;

      // Reset state
      #12;
      check_val("rst_readdata", readdata, 0);
      check_val("rst_done", done, 0);
      check_val("rst_ferr", ferr, 0);
      check_val("rst_busy", busy, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (5) @(posedge clock);

      // Single clean frame
      send_frame(8'hA5, bit_ns, 1'b1);
      settle_and_compare("a5");

      // Back-to-back frames with no idle between them
      send_frame(8'h00, bit_ns, 1'b1);
      send_frame(8'hFF, bit_ns, 1'b1);
      settle_and_compare("b2b");

      // 5-clock low glitch must be rejected
      @(posedge clock);
      #3;
      rx = 1'b0;
      #50;
      check_val("glitch_busy", busy, 1);
      rx = 1'b1;
      settle_and_compare("glitch");

      // Framing error followed by a line held low
      send_frame(8'h3C, bit_ns, 1'b0);
      repeat (40) @(posedge clock);
      #1;
      check_val("break_busy", busy, 1);
      check_val("break_nodone", got_q.size(), 0);
      check_val("break_ferr", ferr_seen, ferr_exp);
      rx = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      check_val("break_release", busy, 0);
      settle_and_compare("break");

      // Asynchronous reset in the middle of the data bits
      v55 = 8'h55;
      @(posedge clock);
      #3;
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 4; i++) begin
         rx = v55[i];
         #(bit_ns);
      end
      rx = v55[4];
      #(bit_ns / 2);
      check_val("mid_busy", busy, 1);
      reset = 1'b1;
      #1;
      check_val("arst_busy", busy, 0);
      check_val("arst_done", done, 0);
      check_val("arst_readdata", readdata, 0);
      last_good = 8'h00;
      rx = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (20) @(posedge clock);
      send_frame(8'h81, bit_ns, 1'b1);
      settle_and_compare("after_reset");

      // Sender bit period about 3% fast and slow
      send_frame(8'hC3, 155, 1'b1);
      settle_and_compare("skew_fast");
      send_frame(8'hC3, 165, 1'b1);
      settle_and_compare("skew_slow");

      // Randomized frames, rates and occasional bad stop bits
      for (int n = 0; n < 20; n++) begin
         b      = 8'($urandom);
         p      = 155 + 5 * $urandom_range(0, 2);
         stop_v = ($urandom_range(0, 5) != 0);
         send_frame(b, p, stop_v);
         if (!stop_v) begin
            repeat ($urandom_range(0, 30)) @(posedge clock);
            rx = 1'b1;
         end
         settle_and_compare($sformatf("rand%0d", n));
      end

      check_val("never_both", both_seen, 0);
      check_val("pulse_width", wide_seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
